// File: rtl/rv151_pkg.sv
// rv151_pkg: shared RV151 constants, load funct3 codes and load FSM states.
// Imported by the data-memory load path.
package rv151_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/load_extend.sv
// load_extend: selects the byte/half/word lane of a read word and
// sign- or zero-extends it according to the RV32I load funct3.
module load_extend (
   input  logic [31:0] word,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);
   import rv151_pkg::*;

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = 8'(word >> {off, 3'b000});
      w_half = off[1] ? word[31:16] : word[15:0];
      result = '0;
      case (funct3)
         LB:      result = {{24{w_byte[7]}}, w_byte};
         LBU:     result = {24'd0, w_byte};
         LH:      result = {{16{w_half[15]}}, w_half};
         LHU:     result = {16'd0, w_half};
         LW:      result = word;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/dmem_load_unit.sv
// dmem_load_unit: issues one word-aligned dmem read per load and extends the result.
// Optional DMEM_LOAD_MISALIGN_CHECK_EN adds io_misalign and skips misaligned accesses.
module dmem_load_unit #(
   parameter int ADDR_W = 32,
   parameter int XLEN   = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_req_valid,
   output logic              io_req_ready,
   input  logic [ADDR_W-1:0] io_req_addr,
   input  logic [2:0]        io_req_funct3,
   input  logic [4:0]        io_req_rd,
   output logic              io_mem_req_valid,
   input  logic              io_mem_req_ready,
   output logic [ADDR_W-1:0] io_mem_req_addr,
   input  logic              io_mem_resp_valid,
   input  logic [XLEN-1:0]   io_mem_resp_data,
   output logic              io_wb_valid,
   output logic [XLEN-1:0]   io_wb_data,
   output logic [4:0]        io_wb_rd,
`ifdef DMEM_LOAD_MISALIGN_CHECK_EN
   output logic              io_misalign,
`endif
   output logic              io_stall
);
   import rv151_pkg::*;

   state_t            r_state;
   logic [1:0]        r_off;
   logic [2:0]        r_f3;
   logic [4:0]        r_rd;
   logic [ADDR_W-1:0] r_addr;
   logic [XLEN-1:0]   r_data;
   logic [31:0]       w_ext;
   logic              w_mis;

   load_extend u_ext (
      .word   (io_mem_resp_data),
      .off    (r_off),
      .funct3 (r_f3),
      .result (w_ext)
   );

`ifdef DMEM_LOAD_MISALIGN_CHECK_EN
   logic r_mis;

   always_comb begin
      w_mis = 1'b0;
      if ((io_req_funct3 == LH) || (io_req_funct3 == LHU))
         w_mis = io_req_addr[0];
      else if (io_req_funct3 == LW)
         w_mis = (io_req_addr[1:0] != 2'b00);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_mis <= 1'b0;
      else if (r_state == IDLE && io_req_valid)
         r_mis <= w_mis;
   end

   assign io_misalign = r_mis & (r_state == RESP);
`else
   assign w_mis = 1'b0;
`endif

   // r_data is cleared on accept so a skipped access writes back 0
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_off   <= '0;
         r_f3    <= '0;
         r_rd    <= '0;
         r_addr  <= '0;
         r_data  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (io_req_valid) begin
                  r_off   <= io_req_addr[1:0];
                  r_f3    <= io_req_funct3;
                  r_rd    <= io_req_rd;
                  r_addr  <= {io_req_addr[ADDR_W-1:2], 2'b00};
                  r_data  <= '0;
                  r_state <= w_mis ? RESP : ISSUE;
               end
            end
            ISSUE: begin
               if (io_mem_req_ready)
                  r_state <= WAIT;
            end
            WAIT: begin
               if (io_mem_resp_valid) begin
                  r_data  <= w_ext;
                  r_state <= RESP;
               end
            end
            RESP:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign io_req_ready     = (r_state == IDLE);
   assign io_mem_req_valid = (r_state == ISSUE);
   assign io_mem_req_addr  = r_addr;
   assign io_wb_valid      = (r_state == RESP);
   assign io_wb_data       = r_data;
   assign io_wb_rd         = r_rd;
   assign io_stall         = (r_state != IDLE);

endmodule

// File: tb/tb_dmem_load_unit.sv
// tb_dmem_load_unit: directed-vector bench for dmem_load_unit.
// Build with +define+DMEM_LOAD_MISALIGN_CHECK_EN to cover io_misalign.
module tb_dmem_load_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        io_req_valid = 1'b0;
   logic        io_req_ready;
   logic [31:0] io_req_addr = '0;
   logic [2:0]  io_req_funct3 = '0;
   logic [4:0]  io_req_rd = '0;
   logic        io_mem_req_valid;
   logic        io_mem_req_ready = 1'b0;
   logic [31:0] io_mem_req_addr;
   logic        io_mem_resp_valid = 1'b0;
   logic [31:0] io_mem_resp_data = '0;
   logic        io_wb_valid;
   logic [31:0] io_wb_data;
   logic [4:0]  io_wb_rd;
   logic        io_stall;
`ifdef DMEM_LOAD_MISALIGN_CHECK_EN
   logic        io_misalign;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   dmem_load_unit #(.ADDR_W(32), .XLEN(32)) dut (
      .clock             (clock),
      .reset             (reset),
      .io_req_valid      (io_req_valid),
      .io_req_ready      (io_req_ready),
      .io_req_addr       (io_req_addr),
      .io_req_funct3     (io_req_funct3),
      .io_req_rd         (io_req_rd),
      .io_mem_req_valid  (io_mem_req_valid),
      .io_mem_req_ready  (io_mem_req_ready),
      .io_mem_req_addr   (io_mem_req_addr),
      .io_mem_resp_valid (io_mem_resp_valid),
      .io_mem_resp_data  (io_mem_resp_data),
      .io_wb_valid       (io_wb_valid),
      .io_wb_data        (io_wb_data),
      .io_wb_rd          (io_wb_rd),
`ifdef DMEM_LOAD_MISALIGN_CHECK_EN
      .io_misalign       (io_misalign),
`endif
      .io_stall          (io_stall)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called just after a rising edge with the unit in IDLE.
   task automatic run_load(input string tag, input logic [31:0] addr,
                           input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] data, input int rdy_dly,
                           input int resp_dly, input logic [31:0] exp,
                           input bit hold, input logic [31:0] n_addr,
                           input logic [2:0] n_f3, input logic [4:0] n_rd);
      logic [31:0] wa;
      int n;
      wa = {addr[31:2], 2'b00};
      io_req_valid      = 1'b1;
      io_req_addr       = addr;
      io_req_funct3     = f3;
      io_req_rd         = rd;
      io_mem_resp_valid = 1'b1;
      io_mem_resp_data  = 32'hDEAD_BEEF;
      io_mem_req_ready  = (rdy_dly == 0);
      @(negedge clock);
      check({tag, " acc_ready"}, io_req_ready, 1);
      check({tag, " acc_wbv"}, io_wb_valid, 0);
      check({tag, " acc_mreqv"}, io_mem_req_valid, 0);
      @(posedge clock); #1;
      io_mem_resp_valid = 1'b0;
      if (hold) begin
         io_req_addr   = n_addr;
         io_req_funct3 = n_f3;
         io_req_rd     = n_rd;
      end else begin
         io_req_valid = 1'b0;
      end
      n = 0;
      forever begin
         @(negedge clock);
         check({tag, " iss_mreqv"}, io_mem_req_valid, 1);
         check({tag, " iss_maddr"}, io_mem_req_addr, wa);
         check({tag, " iss_stall"}, io_stall, 1);
         check({tag, " iss_ready"}, io_req_ready, 0);
         if (io_mem_req_ready || n > 20) break;
         @(posedge clock); #1;
         n++;
         io_mem_resp_valid = 1'b1;
         if (n >= rdy_dly) io_mem_req_ready = 1'b1;
      end
      @(posedge clock); #1;
      io_mem_req_ready  = 1'b0;
      io_mem_resp_valid = 1'b0;
      repeat (resp_dly) begin
         @(negedge clock);
         check({tag, " wait_stall"}, io_stall, 1);
         check({tag, " wait_mreqv"}, io_mem_req_valid, 0);
         check({tag, " wait_wbv"}, io_wb_valid, 0);
         @(posedge clock); #1;
      end
      io_mem_resp_valid = 1'b1;
      io_mem_resp_data  = data;
      @(negedge clock);
      check({tag, " resp_stall"}, io_stall, 1);
      check({tag, " resp_wbv"}, io_wb_valid, 0);
      @(posedge clock); #1;
      io_mem_resp_valid = 1'b0;
      io_mem_resp_data  = 32'hDEAD_BEEF;
      @(negedge clock);
      check({tag, " wb_valid"}, io_wb_valid, 1);
      check({tag, " wb_data"}, io_wb_data, exp);
      check({tag, " wb_rd"}, {27'd0, io_wb_rd}, {27'd0, rd});
      check({tag, " wb_stall"}, io_stall, 1);
      check({tag, " wb_ready"}, io_req_ready, 0);
      @(posedge clock); #1;
      if (!hold) io_req_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset values
      @(negedge clock);
      check("rst_ready", io_req_ready, 1);
      check("rst_mreqv", io_mem_req_valid, 0);
      check("rst_wbv", io_wb_valid, 0);
      check("rst_wbdata", io_wb_data, 0);
      check("rst_stall", io_stall, 0);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;

      // Reset asserted while waiting for the response
      io_req_valid     = 1'b1;
      io_req_addr      = 32'h0000_1003;
      io_req_funct3    = 3'b000;
      io_req_rd        = 5'd4;
      io_mem_req_ready = 1'b1;
      @(posedge clock); #1;
      io_req_valid = 1'b0;
      @(posedge clock); #1;
      io_mem_req_ready = 1'b0;
      @(negedge clock);
      check("abort_pre_stall", io_stall, 1);
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      check("abort_ready", io_req_ready, 1);
      check("abort_stall", io_stall, 0);
      check("abort_mreqv", io_mem_req_valid, 0);
      check("abort_wbrd", {27'd0, io_wb_rd}, 0);
      io_mem_resp_valid = 1'b1;
      io_mem_resp_data  = 32'h80FF_1234;
      @(negedge clock);
      check("abort_wbv", io_wb_valid, 0);
      check("abort_wbdata", io_wb_data, 0);
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (3) begin
         @(negedge clock);
         check("late_wbv", io_wb_valid, 0);
         check("late_stall", io_stall, 0);
         check("late_ready", io_req_ready, 1);
         @(posedge clock); #1;
      end
      io_mem_resp_valid = 1'b0;

      // Minimum-latency loads and extension variants
      run_load("lb_sign", 32'h0000_1003, 3'b000, 5'd5, 32'h80FF_1234,
               0, 0, 32'hFFFF_FF80, 0, '0, '0, '0);
      run_load("lb_pos", 32'h0000_1001, 3'b000, 5'd6, 32'h80FF_1234,
               0, 0, 32'h0000_0012, 0, '0, '0, '0);
      run_load("lhu", 32'h0000_2002, 3'b101, 5'd10, 32'hBEEF_0000,
               0, 0, 32'h0000_BEEF, 0, '0, '0, '0);
      run_load("lbu", 32'h0000_2002, 3'b100, 5'd11, 32'hBEEF_0000,
               0, 0, 32'h0000_00EF, 0, '0, '0, '0);
      run_load("lh_lo", 32'h0000_1000, 3'b001, 5'd12, 32'h80FF_1234,
               0, 0, 32'h0000_1234, 0, '0, '0, '0);
      run_load("lh_hi", 32'h0000_1002, 3'b001, 5'd13, 32'h80FF_1234,
               0, 0, 32'hFFFF_80FF, 0, '0, '0, '0);
      run_load("f3_011", 32'h0000_1000, 3'b011, 5'd14, 32'h80FF_1234,
               0, 0, 32'h0000_0000, 0, '0, '0, '0);
      run_load("f3_110", 32'h0000_1000, 3'b110, 5'd15, 32'h80FF_1234,
               0, 0, 32'h0000_0000, 0, '0, '0, '0);

      // Backpressure and variable latency
      run_load("bp", 32'h0000_5008, 3'b010, 5'd20, 32'hCAFE_F00D,
               3, 5, 32'hCAFE_F00D, 0, '0, '0, '0);

      // Back-to-back LW with the second request held valid
      run_load("b2b1", 32'h0000_4004, 3'b010, 5'd7, 32'h1122_3344,
               0, 0, 32'h1122_3344, 1, 32'h0000_4108, 3'b010, 5'd9);
      run_load("b2b2", 32'h0000_4108, 3'b010, 5'd9, 32'h5566_7788,
               1, 2, 32'h5566_7788, 0, '0, '0, '0);

`ifdef DMEM_LOAD_MISALIGN_CHECK_EN
      io_req_valid  = 1'b1;
      io_req_addr   = 32'h0000_3002;
      io_req_funct3 = 3'b010;
      io_req_rd     = 5'd3;
      @(negedge clock);
      check("mis_acc_ready", io_req_ready, 1);
      @(posedge clock); #1;
      io_req_valid = 1'b0;
      @(negedge clock);
      check("mis_wbv", io_wb_valid, 1);
      check("mis_flag", io_misalign, 1);
      check("mis_wbdata", io_wb_data, 0);
      check("mis_wbrd", {27'd0, io_wb_rd}, 32'd3);
      check("mis_mreqv", io_mem_req_valid, 0);
      @(posedge clock); #1;
      @(negedge clock);
      check("mis_after_wbv", io_wb_valid, 0);
      check("mis_after_flag", io_misalign, 0);
      check("mis_after_ready", io_req_ready, 1);
      @(posedge clock); #1;
      run_load("lh_al_chk", 32'h0000_2002, 3'b001, 5'd8, 32'hBEEF_0000,
               0, 0, 32'hFFFF_BEEF, 0, '0, '0, '0);
`else
      run_load("lw_mis", 32'h0000_2002, 3'b010, 5'd16, 32'hBEEF_0000,
               0, 0, 32'hBEEF_0000, 0, '0, '0, '0);
      run_load("lh_mis", 32'h0000_2003, 3'b001, 5'd17, 32'hBEEF_0000,
               0, 0, 32'hFFFF_BEEF, 0, '0, '0, '0);
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dmem_load_unit.md
Name: dmem_load_unit

Overview:
- Load-side counterpart of the store-data path of the RV151 data memory.
- Accepts one load request from the execute stage and issues a word-aligned read to dmem with a valid/ready request channel.
- Waits a variable number of cycles for the read response, then extracts the byte, half or word and sign- or zero-extends it.
- Returns the result to writeback, and stalls the pipeline while the load is outstanding.

Parameters:
- ADDR_W, 32, byte-address width of io_req_addr and io_mem_req_addr.
- XLEN, 32, data width; fixed to 32 (RV32I), no other value supported.

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- io_req_valid  in  1  load request from EX
- io_req_ready  out  1  unit can accept a request
- io_req_addr  in  ADDR_W  byte address
- io_req_funct3  in  3  RV32I load funct3
- io_req_rd  in  5  destination register
- io_mem_req_valid  out  1  read request to dmem
- io_mem_req_ready  in  1  dmem accepts request
- io_mem_req_addr  out  ADDR_W  word address; bits [1:0] always 0
- io_mem_resp_valid  in  1  read data valid
- io_mem_resp_data  in  XLEN  full read word
- io_wb_valid  out  1  one-cycle writeback strobe
- io_wb_data  out  XLEN  extended load result
- io_wb_rd  out  5  destination register for io_wb_data
- io_stall  out  1  holds the pipeline while a load is in flight

Behaviour:
- Clock and reset: one clock (clock); reset is asynchronous and active-low (reset).
- Reset state: FSM in IDLE; all registers 0; io_mem_req_valid=0, io_wb_valid=0, io_wb_data=0, io_wb_rd=0, io_stall=0, io_req_ready=1.
- Reset asserted mid-operation aborts the load immediately; no writeback is produced, and a late io_mem_resp_valid is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - io_req_ready=1.
  - On io_req_valid: latch addr[1:0], funct3, rd and {addr[ADDR_W-1:2],2'b00}, then go to ISSUE.
- ISSUE:
  - io_mem_req_valid=1 with the latched word address.
  - Valid and address stay stable until io_mem_req_ready; then go to WAIT.
- WAIT: on io_mem_resp_valid, register the extracted result, then go to RESP.
- RESP: io_wb_valid=1 for exactly one cycle with io_wb_data and io_wb_rd, then go to IDLE.
- io_req_ready=1 only in IDLE. io_stall=1 in ISSUE, WAIT and RESP.
- io_mem_resp_valid is ignored outside WAIT.
- Minimum latency: accept at cycle 0, mem request at cycle 1 (ready=1), response at cycle 2, io_wb_valid at cycle 3.
- A new request can be accepted in the cycle after RESP.
- Extraction:
  - Byte lane = data[8*off+7 : 8*off], where off = addr[1:0].
  - Half lane = addr[1] ? data[31:16] : data[15:0].
  - Word = data.
- Extension by funct3:
  - 000 LB: sign-extend byte.
  - 100 LBU: zero-extend byte.
  - 001 LH: sign-extend half.
  - 101 LHU: zero-extend half.
  - 010 LW: word unchanged.
  - 011, 110, 111: still perform the access; result is 0.
- Misalignment without the optional feature:
  - LH/LHU ignore addr[0].
  - LW ignores addr[1:0].
  - No error is flagged.

Optional Feature:
- Macro: DMEM_LOAD_MISALIGN_CHECK_EN.
- When defined, adds output io_misalign (1 bit, reset 0).
- A request is misaligned when: LH/LHU with addr[0]=1, or LW with addr[1:0]≠0.
- A misaligned request is accepted, skips ISSUE and WAIT (no dmem request is issued), and goes IDLE→RESP.
- In RESP: io_wb_valid=1, io_wb_data=0, io_misalign=1 for that one cycle.
- When not defined: no io_misalign port; behaviour as in Behaviour above.

Decomposition:
- Shared package rv151_pkg holds:
  - funct3 load constants (LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100, LHU=3'b101);
  - the FSM state enum (IDLE, ISSUE, WAIT, RESP);
  - the XLEN constant.
- One natural combinational sub-module, load_extend, with inputs word, off[1:0], funct3 and output result[31:0]. It is reused by any future cache or MMIO read path.

Test Plan:
- Reset: reset low mid-WAIT, then a response arrives → no io_wb_valid; all outputs 0; io_req_ready=1 after release.
- LB sign: addr=0x1003, mem data 0x80FF_1234, ready=1, response after 1 cycle → io_mem_req_addr=0x1000; io_wb_data=0xFFFF_FF80 at cycle 3; io_wb_rd echoed.
- LBU/LHU zero-extension: addr=0x2002, data 0xBEEF_0000:
  - LHU → 0x0000_BEEF.
  - LBU → 0x0000_00EF.
- Backpressure and variable latency: io_mem_req_ready low 3 cycles, response 5 cycles later → io_mem_req_valid and address held steady; io_stall high throughout; exactly one io_wb_valid pulse.
- Back-to-back LW: second request held valid during the first load → second accepted only in the cycle after RESP; io_mem_resp_valid pulses outside WAIT ignored.
- With DMEM_LOAD_MISALIGN_CHECK_EN, LW addr=0x3002 → no io_mem_req_valid; io_wb_valid=1 and io_misalign=1 at cycle 1; io_wb_data=0.
